// File: rtl/adpll_pkg.sv
// adpll_pkg: shared state encoding and default widths for the ADPLL divider control.
package adpll_pkg;
    typedef enum logic [1:0] {IDLE, PEND, RUN} state_t;
    localparam int M_W_DEF    = 3;
    localparam int FRAC_W_DEF = 4;
endpackage

// File: rtl/frac_accum.sv
// frac_accum: fractional phase accumulator; carry marks a period that needs N+1.
module frac_accum
    import adpll_pkg::*;
#(
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [FRAC_W-1:0] frac,
    output logic              carry
);
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;

    assign sum   = {1'b0, acc} + {1'b0, frac};
    assign carry = sum[FRAC_W];

    always_ff @(posedge clk) begin
        if (reset || clr)
            acc <= '0;
        else if (en)
            acc <= sum[FRAC_W-1:0];
    end
endmodule

// File: rtl/div_ratio_ctrl.sv
// div_ratio_ctrl: accepts N+F/2^FRAC_W ratio configs and sequences the divider ratio M
// at divider period boundaries.
module div_ratio_ctrl
    import adpll_pkg::*;
#(
    parameter int M_W    = M_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [M_W-1:0]    cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic              div_tick,
    output logic [M_W-1:0]    M,
    output logic              apply_pulse,
    output logic              cfg_err,
    output logic              running
);
    state_t            state, state_nx;
    logic [M_W-1:0]    sh_n, act_n, m_nx;
    logic [FRAC_W-1:0] sh_f, act_f;
    logic              acc_ok, bad, take, tick_run, apply, stop, carry;
    logic              ap_q, err_q;

    frac_accum #(.FRAC_W(FRAC_W)) u_accum (
        .clk   (clk),
        .reset (reset),
        .en    (tick_run),
        .clr   (apply),
        .frac  (act_f),
        .carry (carry)
    );

    always_comb begin
        acc_ok   = cfg_valid && state != PEND;
        // N=max with a fraction would overflow N+1; N=1 with a fraction is meaningless
        bad      = acc_ok && cfg_frac != '0 && (cfg_int == '1 || cfg_int == M_W'(1));
        take     = acc_ok && !bad;
        tick_run = div_tick && state == RUN;
        apply    = div_tick && state == PEND;
        stop     = apply && sh_n == '0;
        state_nx = take ? PEND : apply ? (stop ? IDLE : RUN) : state;
        m_nx     = apply ? (stop ? M_W'(1) : sh_n) : tick_run ? act_n + M_W'(carry) : M;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            M     <= M_W'(1);
            sh_n  <= '0;
            sh_f  <= '0;
            act_n <= '0;
            act_f <= '0;
            ap_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            M     <= m_nx;
            ap_q  <= apply;
            err_q <= bad;
            if (take) begin
                sh_n <= cfg_int;
                sh_f <= cfg_frac;
            end
            if (apply && !stop) begin
                act_n <= sh_n;
                act_f <= sh_f;
            end
        end
    end

    assign cfg_ready   = !reset && state != PEND;
    assign running     = !reset && state == RUN;
    assign apply_pulse = !reset && ap_q;
    assign cfg_err     = !reset && err_q;
endmodule

// File: tb/tb_div_ratio_ctrl.sv
// tb_div_ratio_ctrl: directed scenarios plus random traffic against an arithmetic ratio model.
module tb_div_ratio_ctrl;
    logic       clk = 1'b0;
    logic       reset, cfg_valid, div_tick;
    logic       cfg_ready, apply_pulse, cfg_err, running;
    logic [2:0] cfg_int, M;
    logic [3:0] cfg_frac;

    int errors = 0;
    int checks = 0;
    // model: mode 0=idle 1=pending 2=running; k counts ticks since apply
    int mode, mm, map, mer, sn, sf, an, af, k;
    int seq[9] = '{3, 3, 3, 3, 4, 3, 3, 3, 4};

    div_ratio_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_int     (cfg_int),
        .cfg_frac    (cfg_frac),
        .div_tick    (div_tick),
        .M           (M),
        .apply_pulse (apply_pulse),
        .cfg_err     (cfg_err),
        .running     (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int v, input int n, input int f, input int t, input int r);
        int acc, bad;
        reset     = r[0];
        cfg_valid = v[0];
        cfg_int   = n[2:0];
        cfg_frac  = f[3:0];
        div_tick  = t[0];
        #1;
        chk("cfg_ready", int'(cfg_ready), (r == 0 && mode != 1) ? 1 : 0);
        @(posedge clk);
        #1;
        if (r != 0) begin
            mode = 0; mm = 1; map = 0; mer = 0;
        end else begin
            acc = (v != 0 && mode != 1) ? 1 : 0;
            bad = (acc != 0 && f != 0 && (n == 7 || n == 1)) ? 1 : 0;
            map = 0;
            mer = bad;
            if (t != 0 && mode == 2) begin
                k++;
                mm = an + (k * af) / 16 - ((k - 1) * af) / 16;
            end else if (t != 0 && mode == 1) begin
                map = 1;
                if (sn == 0) begin
                    mm = 1; mode = 0;
                end else begin
                    an = sn; af = sf; k = 0; mm = an; mode = 2;
                end
            end
            if (acc != 0 && bad == 0) begin
                sn = n; sf = f; mode = 1;
            end
        end
        chk("M", int'(M), mm);
        chk("apply_pulse", int'(apply_pulse), map);
        chk("cfg_err", int'(cfg_err), mer);
        chk("running", int'(running), mode == 2 ? 1 : 0);
    endtask

    task automatic idle(input int c);
        for (int i = 0; i < c; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        mode = 0; mm = 1; map = 0; mer = 0; sn = 0; sf = 0; an = 0; af = 0; k = 0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("rst_M", int'(M), 1);
        idle(1);
        // basic fractional sequencing N=3 F=4
        step(1, 3, 4, 0, 0);
        idle(2);
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 0, 1, 0);
            chk("seq_m", int'(M), seq[i]);
            idle(1);
        end
        // rejection while running
        step(1, 7, 1, 0, 0);
        chk("rej_err", int'(cfg_err), 1);
        idle(1);
        // integer mode with backpressure
        step(1, 5, 0, 0, 0);
        chk("pend_ready", int'(cfg_ready), 0);
        idle(2);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1, 0);
            chk("int_m", int'(M), 5);
        end
        // tick coinciding with accept
        step(1, 3, 8, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 4, 0, 1, 0);
        chk("coinc_old", int'(M), 4);
        step(0, 0, 0, 1, 0);
        chk("coinc_new", int'(M), 4);
        chk("coinc_ap", int'(apply_pulse), 1);
        idle(1);
        // stop request
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("stop_m", int'(M), 1);
        chk("stop_run", int'(running), 0);
        // reset mid-pending
        step(1, 3, 4, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        chk("rst_pend_ap", int'(apply_pulse), 0);
        step(0, 0, 0, 1, 0);
        chk("rst_pend_m", int'(M), 1);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 7),
                 ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15),
                 ($urandom_range(0, 2) == 0) ? 1 : 0,
                 ($urandom_range(0, 199) == 0) ? 1 : 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
